ifid_fetch_unit: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the 16-bit dual-issue pipeline.
- Each fetch returns one 32-bit word holding two instructions:
  - g1 = bits [15:0], the lower address.
  - g2 = bits [31:16].
- Consumes the stall controls from the hazard detector: PCWrite, IFWrite.
- Consumes the EX-stage branch redirect.
- Produces the instruction pair decoded in ID.
- Owns the PC, a single-outstanding instruction-memory handshake, and a one-entry skid buffer.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/ifid_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_ifid_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W     = 16;
  localparam int FETCH_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that arrives while IF/ID is stalled.
module fetch_skid_buf #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_word,
  input  logic [PC_W-1:0]   load_pc,
  output logic              full,
  output logic [DATA_W-1:0] word,
  output logic [PC_W-1:0]   pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      word <= '0;
      pc   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      word <= load_word;
      pc   <= load_pc;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ifid_fetch_unit.sv
// Instruction fetch + IF/ID register: PC, single-outstanding imem handshake, skid buffer.
// Optional saturating perf counters (stall_cycles, squash_count) under FETCH_PERF_CNT_EN.
module ifid_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                PCWrite,
  input  logic                IFWrite,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                ifid_valid,
  output logic [PC_W-1:0]     ifid_pc,
  output logic [INSTR_W-1:0]  ifid_instr_g1,
  output logic [INSTR_W-1:0]  ifid_instr_g2,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         squash_count,
`endif
  output fetch_state_t        fsm_state
);

  // Handshake: imem_req is high for exactly one cycle (FETCH) and the request
  // is accepted in that cycle; the single response is taken only in WAIT when
  // imem_rvalid is high. rvalid seen in any other state is ignored.

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            squash;
  logic            half_skip;

  logic [PC_W-1:0] pc_base;
  logic            rsp;
  logic            discard;
  logic            load_from_mem;
  logic            load_from_skid;
  logic            skid_store;
  logic            ifid_load;
  logic [31:0]     load_word;
  logic [PC_W-1:0] load_pc;

  logic            skid_full;
  logic [31:0]     skid_word;
  logic [PC_W-1:0] skid_pc;

  logic            unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  assign imem_addr = pc_base;
  assign fsm_state = state;

  always_comb begin
    pc_base        = {pc[PC_W-1:2], 2'b00};
    rsp            = (state == WAIT) && imem_rvalid;
    discard        = rsp && (squash || branch_taken);
    load_from_mem  = rsp && !squash && !branch_taken && IFWrite;
    skid_store     = rsp && !squash && !branch_taken && !IFWrite;
    load_from_skid = (state == HOLD) && skid_full && !branch_taken && IFWrite;
    ifid_load      = load_from_mem || load_from_skid;
    load_word      = load_from_skid ? skid_word : imem_rdata;
    load_pc        = load_from_skid ? skid_pc : pc_base;
  end

  fetch_skid_buf #(
    .PC_W   (PC_W),
    .DATA_W (32)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_store),
    .unload    (load_from_skid),
    .clear     (branch_taken),
    .load_word (imem_rdata),
    .load_pc   (pc_base),
    .full      (skid_full),
    .word      (skid_word),
    .pc        (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      squash        <= 1'b0;
      half_skip     <= 1'b0;
      imem_req      <= 1'b0;
      ifid_valid    <= 1'b0;
      ifid_pc       <= '0;
      ifid_instr_g1 <= NOP_INSTR;
      ifid_instr_g2 <= NOP_INSTR;
    end else if (branch_taken) begin
      ifid_valid    <= 1'b0;
      ifid_instr_g1 <= NOP_INSTR;
      ifid_instr_g2 <= NOP_INSTR;
      pc            <= branch_target;
      half_skip     <= branch_target[1];
      // A request issued this cycle or still pending must be drained before
      // refetching, so the one-outstanding rule holds.
      if ((state == FETCH) || ((state == WAIT) && !imem_rvalid)) begin
        state    <= WAIT;
        squash   <= 1'b1;
        imem_req <= 1'b0;
      end else begin
        state    <= FETCH;
        squash   <= 1'b0;
        imem_req <= 1'b1;
      end
    end else begin
      if (ifid_load) begin
        ifid_valid    <= 1'b1;
        ifid_pc       <= load_pc;
        ifid_instr_g1 <= half_skip ? NOP_INSTR : load_word[15:0];
        ifid_instr_g2 <= load_word[31:16];
        half_skip     <= 1'b0;
        if (PCWrite) begin
          pc <= pc_base + PC_W'(FETCH_BYTES);
        end
      end else if (IFWrite) begin
        ifid_valid    <= 1'b0;
        ifid_instr_g1 <= NOP_INSTR;
        ifid_instr_g2 <= NOP_INSTR;
      end

      imem_req <= 1'b0;
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          if (rsp) begin
            if (squash) begin
              squash   <= 1'b0;
              state    <= FETCH;
              imem_req <= 1'b1;
            end else if (IFWrite) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (IFWrite) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else begin
      if (!IFWrite && ifid_valid && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (discard && (squash_count != '1)) begin
        squash_count <= squash_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifid_fetch_unit.sv
// Directed bench for ifid_fetch_unit: cycle table plus hand-written corner sequences.
module tb_ifid_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         PCWrite;
  logic         IFWrite;
  logic         branch_taken;
  logic [15:0]  branch_target;
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         ifid_valid;
  logic [15:0]  ifid_pc;
  logic [15:0]  ifid_instr_g1;
  logic [15:0]  ifid_instr_g2;
  fetch_state_t fsm_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  stall_cycles;
  logic [31:0]  squash_count;
`endif

  int total = 0;
  int bad   = 0;

  ifid_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (PCWrite),
    .IFWrite       (IFWrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr_g1 (ifid_instr_g1),
    .ifid_instr_g2 (ifid_instr_g2),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .squash_count  (squash_count),
`endif
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model state
  bit          mem_auto;
  int          mem_lat;
  bit          pend;
  int          cnt;
  logic [15:0] paddr;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = a + 16'h2222;
    lo = a + 16'h1111;
    return {hi, lo};
  endfunction

  task automatic mem_step();
    if (!mem_auto) return;
    imem_rvalid = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    if (imem_req) begin
      pend  = 1'b1;
      paddr = imem_addr;
      cnt   = mem_lat - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    IFWrite       = 1'b1;
    PCWrite       = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    pend          = 1'b0;
    mem_auto      = 1'b1;
    mem_lat       = 1;
    tick();
    tick();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_pc",    32'(ifid_pc), 32'h0);
    chk("rst_g1",    32'(ifid_instr_g1), 32'(NOP_INSTR));
    chk("rst_g2",    32'(ifid_instr_g2), 32'(NOP_INSTR));
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (ifid_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_valid", 32'(ok), 32'd1);
  endtask

  task automatic chk_pair(input string name, input logic [15:0] pc,
                          input logic [15:0] g1, input logic [15:0] g2);
    chk({name, "_valid"}, 32'(ifid_valid), 32'd1);
    chk({name, "_pc"},    32'(ifid_pc), 32'(pc));
    chk({name, "_g1"},    32'(ifid_instr_g1), 32'(g1));
    chk({name, "_g2"},    32'(ifid_instr_g2), 32'(g2));
  endtask

  typedef struct {
    logic        ifw;
    logic        pcw;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] g1;
    logic [15:0] g2;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ifw, input logic pcw, input logic br,
                              input logic [15:0] tgt, input logic req,
                              input logic [15:0] addr, input logic valid,
                              input logic [15:0] pc, input logic [15:0] g1,
                              input logic [15:0] g2);
    vec_t v;
    v.ifw = ifw; v.pcw = pcw; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.g1 = g1; v.g2 = g2;
    return v;
  endfunction

  initial begin
    // Cycle table from reset release, 1-cycle memory. Each row: inputs for the
    // next edge, then expected outputs just after it.
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h1111, 16'h2222));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0000, 16'h1111, 16'h2222));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0000, 16'h1111, 16'h2222));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0000, 16'h1111, 16'h2222));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0004, 16'h1115, 16'h2226));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b1, 16'h0008, 16'h1119, 16'h222A));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0042, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0040, 16'h0000, 16'h2262));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0048, 1'b1, 16'h0044, 16'h1155, 16'h2266));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0048, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0048, 1'b1, 16'h0048, 16'h1159, 16'h226A));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0048, 1'b0, 16'h0000, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h004C, 1'b1, 16'h0048, 16'h1159, 16'h226A));

    do_reset();
    foreach (vq[i]) begin
      IFWrite       = vq[i].ifw;
      PCWrite       = vq[i].pcw;
      branch_taken  = vq[i].br;
      branch_target = vq[i].tgt;
      tick();
      chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(vq[i].req));
      chk($sformatf("v%0d_addr", i),  32'(imem_addr), 32'(vq[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(ifid_valid), 32'(vq[i].valid));
      chk($sformatf("v%0d_g1", i),    32'(ifid_instr_g1), 32'(vq[i].g1));
      chk($sformatf("v%0d_g2", i),    32'(ifid_instr_g2), 32'(vq[i].g2));
      if (vq[i].valid) chk($sformatf("v%0d_pc", i), 32'(ifid_pc), 32'(vq[i].pc));
    end
    branch_taken = 1'b0;

    // Branch while waiting on a 3-cycle memory: the late response is dropped.
    do_reset();
    mem_lat = 3;
    tick();
    tick();
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_taken  = 1'b0;
    chk("sq_req_hold", 32'(imem_req), 32'd0);
    chk("sq_state",    32'(fsm_state), 32'(WAIT));
    tick();
    chk("sq_req_still", 32'(imem_req), 32'd0);
    tick();
    chk("sq_valid", 32'(ifid_valid), 32'd0);
    chk("sq_req",   32'(imem_req), 32'd1);
    chk("sq_addr",  32'(imem_addr), 32'h0040);
    wait_valid(12);
    chk_pair("sq_load", 16'h0040, 16'h1151, 16'h2262);
    chk("sq_next_addr", 32'(imem_addr), 32'h0044);

    // Branch together with IFWrite = 0 still flushes IF/ID.
    do_reset();
    wait_valid(6);
    chk_pair("fl_first", 16'h0000, 16'h1111, 16'h2222);
    IFWrite       = 1'b0;
    PCWrite       = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h0080;
    tick();
    branch_taken = 1'b0;
    chk("fl_valid", 32'(ifid_valid), 32'd0);
    chk("fl_g1",    32'(ifid_instr_g1), 32'(NOP_INSTR));
    chk("fl_g2",    32'(ifid_instr_g2), 32'(NOP_INSTR));
    IFWrite = 1'b1;
    PCWrite = 1'b1;
    wait_valid(10);
    chk_pair("fl_target", 16'h0080, 16'h1191, 16'h22A2);

    // Reset mid-WAIT, then a late response arrives and must be ignored.
    do_reset();
    wait_valid(6);
    mem_auto = 1'b0;
    pend     = 1'b0;
    tick();
    chk("rw_state_wait", 32'(fsm_state), 32'(WAIT));
    rst_n = 1'b0;
    tick();
    chk("rw_req",   32'(imem_req), 32'd0);
    chk("rw_valid", 32'(ifid_valid), 32'd0);
    chk("rw_pc",    32'(ifid_pc), 32'h0);
    chk("rw_g1",    32'(ifid_instr_g1), 32'(NOP_INSTR));
    chk("rw_addr",  32'(imem_addr), 32'h0000);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("rw_late_valid", 32'(ifid_valid), 32'd0);
    chk("rw_restart_req",  32'(imem_req), 32'd1);
    chk("rw_restart_addr", 32'(imem_addr), 32'h0000);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(16'h0000);
    tick();
    imem_rvalid = 1'b0;
    chk_pair("rw_load", 16'h0000, 16'h1111, 16'h2222);
    mem_auto = 1'b1;

    // PC wrap: a word at 16'hFFFC is followed by a fetch of address 0.
    do_reset();
    tick();
    tick();
    branch_taken  = 1'b1;
    branch_target = 16'hFFFC;
    tick();
    branch_taken = 1'b0;
    chk("wr_addr", 32'(imem_addr), 32'hFFFC);
    wait_valid(6);
    chk_pair("wr_load", 16'hFFFC, 16'h110D, 16'h221E);
    chk("wr_next_addr", 32'(imem_addr), 32'h0000);
    chk("wr_next_req",  32'(imem_req), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("pc_squash_count", squash_count, 32'd1);
    chk("pc_stall_cycles", stall_cycles, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
